instr_fetch_stage: RTL and testbench

//  - Fetch stage upstream of InstMem: owns the PC, drives Pc to InstMem and captures InstReg in the same cycle.
//  - Loads the captured instruction into the IF/ID pipeline register for decode.
//  - Handles stall, branch/jump redirect, flush and halt.

---
 rtl/instr_fetch_stage_pkg.sv | 19 +
 rtl/instr_fetch_stage_if_id_reg.sv | 28 ++
 rtl/instr_fetch_stage.sv | 119 +++++++++++
 tb/tb_instr_fetch_stage.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_stage_pkg.sv
// Shared types for the fetch stage: FSM state, IF/ID bundle, constants.
// Imported by instr_fetch_stage and if_id_reg.
package instr_fetch_stage_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
  localparam logic [31:0] PC_STEP  = 32'd4;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc_plus4;
    logic        valid;
  } if_id_t;

endpackage

// File: rtl/instr_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: rst > clr > ld > hold.
// Ports: clk, rst (sync, high), ld, clr, d (if_id_t), q (if_id_t).
module if_id_reg
  import instr_fetch_stage_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   ld,
  input  logic   clr,
  input  if_id_t d,
  output if_id_t q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q.inst     <= NOP_WORD;
      q.pc_plus4 <= '0;
      q.valid    <= 1'b0;
    end else if (clr) begin
      // a bubble keeps the old pc_plus4
      q.inst  <= NOP_WORD;
      q.valid <= 1'b0;
    end else if (ld) begin
      q <= d;
    end
  end

endmodule

// File: rtl/instr_fetch_stage.sv
// Fetch stage: PC register, next-PC mux, RUN/HALT FSM, fetch counter.
// Ports: Clk, Reset (sync, high), Stall, Flush, BranchTaken/Target,
//   Jump/JumpTarget, InstReg -> Pc, IfId{Inst,PcPlus4,Valid}, Halted,
//   FetchCount, MisalignErr. Macro PC_MISALIGN_CHECK_EN enables the flag.
module instr_fetch_stage
  import instr_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_WORDS = 1024,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  input  logic [31:0] InstReg,
  output logic [31:0] Pc,
  output logic [31:0] IfIdInst,
  output logic [31:0] IfIdPcPlus4,
  output logic        IfIdValid,
  output logic        Halted,
  output logic [31:0] FetchCount,
  output logic        MisalignErr
);

  localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pc_inc;
  logic [31:0]  tgt;
  logic         redir;
  logic         ld, clr;
  logic [31:0]  cnt_q;
  if_id_t       ifid_d, ifid_q;

  assign pc_inc = (pc_q + PC_STEP) % MEM_BYTES;
  assign redir  = Jump | BranchTaken;
  assign tgt    = Jump ? JumpTarget : BranchTarget;

  assign ifid_d.inst     = InstReg;
  assign ifid_d.pc_plus4 = pc_inc;
  assign ifid_d.valid    = 1'b1;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (ld && cnt_q != 32'hFFFF_FFFF)
        cnt_q <= cnt_q + 32'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ld      = 1'b0;
    clr     = 1'b0;
    unique case (state_q)
      RUN: begin
        if (redir) begin
          pc_d = tgt & ~32'h3;
          clr  = 1'b1;
        end else begin
          if (Flush)       clr = 1'b1;
          else if (!Stall) ld  = 1'b1;
          // the PC parks on the halt word's address
          if (ld && InstReg == HALT_WORD)
            state_d = HALT;
          else if (!Stall)
            pc_d = pc_inc;
        end
      end
      HALT: begin
        clr = 1'b1;
      end
    endcase
  end

`ifdef PC_MISALIGN_CHECK_EN
  logic mis_q;

  always_ff @(posedge Clk) begin
    if (Reset)
      mis_q <= 1'b0;
    else if (state_q == RUN && redir && tgt[1:0] != 2'b00)
      mis_q <= 1'b1;
  end

  assign MisalignErr = mis_q;
`else
  assign MisalignErr = 1'b0;
`endif

  if_id_reg u_if_id (
    .clk (Clk),
    .rst (Reset),
    .ld  (ld),
    .clr (clr),
    .d   (ifid_d),
    .q   (ifid_q)
  );

  assign Pc          = pc_q;
  assign IfIdInst    = ifid_q.inst;
  assign IfIdPcPlus4 = ifid_q.pc_plus4;
  assign IfIdValid   = ifid_q.valid;
  assign Halted      = (state_q == HALT);
  assign FetchCount  = cnt_q;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Self-checking bench for instr_fetch_stage: directed table,
// hand sequences (wrap, halt) and randomized run vs a reference model.
module tb_instr_fetch_stage;

`ifdef PC_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  localparam logic [31:0] HW = 32'hFFFF_FFFF;

  logic        Clk;
  logic        Reset, Stall, Flush, BranchTaken, Jump;
  logic [31:0] BranchTarget, JumpTarget, InstReg;
  logic [31:0] Pc, IfIdInst, IfIdPcPlus4, FetchCount;
  logic        IfIdValid, Halted, MisalignErr;

  logic [31:0] mem [1024];

  int n_chk  = 0;
  int n_fail = 0;

  // reference model state
  logic [31:0] m_pc, m_inst, m_pc4, m_cnt;
  bit          m_valid, m_halt, m_mis;

  assign InstReg = mem[Pc[11:2]];

  instr_fetch_stage dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Stall        (Stall),
    .Flush        (Flush),
    .BranchTaken  (BranchTaken),
    .BranchTarget (BranchTarget),
    .Jump         (Jump),
    .JumpTarget   (JumpTarget),
    .InstReg      (InstReg),
    .Pc           (Pc),
    .IfIdInst     (IfIdInst),
    .IfIdPcPlus4  (IfIdPcPlus4),
    .IfIdValid    (IfIdValid),
    .Halted       (Halted),
    .FetchCount   (FetchCount),
    .MisalignErr  (MisalignErr)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [31:0] w(int i);
    return 32'hA000_0000 | 32'(i);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock edge of the specified behaviour, from the current inputs.
  task automatic model_edge();
    logic [31:0] ir;
    logic [31:0] t;
    ir = mem[m_pc[11:2]];
    if (Reset) begin
      m_pc = 0; m_inst = 0; m_pc4 = 0; m_valid = 0;
      m_halt = 0; m_cnt = 0; m_mis = 0;
    end else if (m_halt) begin
      m_inst = 0; m_valid = 0;
    end else if (Jump || BranchTaken) begin
      t = Jump ? JumpTarget : BranchTarget;
      if (MIS_EN && (t % 4) != 0) m_mis = 1;
      m_pc = t - (t % 4);
      m_inst = 0; m_valid = 0;
    end else if (Flush) begin
      m_inst = 0; m_valid = 0;
      if (!Stall) m_pc = (m_pc + 4) % 4096;
    end else if (!Stall) begin
      m_inst = ir;
      m_pc4 = (m_pc + 4) % 4096;
      m_valid = 1;
      if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
      if (ir == HW) m_halt = 1;
      else m_pc = (m_pc + 4) % 4096;
    end
  endtask

  task automatic cyc(bit rst, bit st, bit fl, bit br,
                     logic [31:0] bt, bit jp, logic [31:0] jt);
    Reset = rst; Stall = st; Flush = fl;
    BranchTaken = br; BranchTarget = bt;
    Jump = jp; JumpTarget = jt;
    model_edge();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_model(string tag);
    chk({tag, ".pc"},    Pc,          m_pc);
    chk({tag, ".inst"},  IfIdInst,    m_inst);
    chk({tag, ".pc4"},   IfIdPcPlus4, m_pc4);
    chk({tag, ".valid"}, 32'(IfIdValid), 32'(m_valid));
    chk({tag, ".halt"},  32'(Halted), 32'(m_halt));
    chk({tag, ".cnt"},   FetchCount,  m_cnt);
    chk({tag, ".mis"},   32'(MisalignErr), 32'(m_mis));
  endtask

  typedef struct {
    bit          st, fl, br;
    logic [31:0] bt;
    bit          jp;
    logic [31:0] jt;
    logic [31:0] pc, inst, pc4;
    bit          valid;
    logic [31:0] cnt;
  } vec_t;

  vec_t tbl [13];

  initial begin
    Reset = 1; Stall = 0; Flush = 0; BranchTaken = 0; Jump = 0;
    BranchTarget = 0; JumpTarget = 0;
    for (int i = 0; i < 1024; i++) mem[i] = w(i);

    tbl[0]  = '{0,0,0,0,      0,0,      32'h4,  w(0),  32'h4,  1,1};
    tbl[1]  = '{0,0,0,0,      0,0,      32'h8,  w(1),  32'h8,  1,2};
    tbl[2]  = '{1,0,0,0,      0,0,      32'h8,  w(1),  32'h8,  1,2};
    tbl[3]  = '{1,0,0,0,      0,0,      32'h8,  w(1),  32'h8,  1,2};
    tbl[4]  = '{0,0,0,0,      0,0,      32'hC,  w(2),  32'hC,  1,3};
    tbl[5]  = '{0,0,0,0,      0,0,      32'h10, w(3),  32'h10, 1,4};
    tbl[6]  = '{1,0,1,32'h40, 1,32'h80, 32'h80, 0,     32'h10, 0,4};
    tbl[7]  = '{0,0,0,0,      0,0,      32'h84, w(32), 32'h84, 1,5};
    tbl[8]  = '{0,1,0,0,      0,0,      32'h88, 0,     32'h84, 0,5};
    tbl[9]  = '{0,0,1,32'h40, 0,0,      32'h40, 0,     32'h84, 0,5};
    tbl[10] = '{0,0,0,0,      0,0,      32'h44, w(16), 32'h44, 1,6};
    tbl[11] = '{0,0,0,0,      1,32'h43, 32'h40, 0,     32'h44, 0,6};
    tbl[12] = '{1,1,0,0,      0,0,      32'h40, 0,     32'h44, 0,6};

    // reset state
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("rst.pc",    Pc, 32'h0);
    chk("rst.inst",  IfIdInst, 32'h0);
    chk("rst.pc4",   IfIdPcPlus4, 32'h0);
    chk("rst.valid", 32'(IfIdValid), 0);
    chk("rst.halt",  32'(Halted), 0);
    chk("rst.cnt",   FetchCount, 0);
    chk("rst.mis",   32'(MisalignErr), 0);

    // directed table
    for (int i = 0; i < 13; i++) begin
      cyc(0, tbl[i].st, tbl[i].fl, tbl[i].br, tbl[i].bt,
          tbl[i].jp, tbl[i].jt);
      chk($sformatf("tbl%0d.pc", i),    Pc,          tbl[i].pc);
      chk($sformatf("tbl%0d.inst", i),  IfIdInst,    tbl[i].inst);
      chk($sformatf("tbl%0d.pc4", i),   IfIdPcPlus4, tbl[i].pc4);
      chk($sformatf("tbl%0d.valid", i), 32'(IfIdValid), 32'(tbl[i].valid));
      chk($sformatf("tbl%0d.cnt", i),   FetchCount,  tbl[i].cnt);
    end
    chk("misalign", 32'(MisalignErr), 32'(MIS_EN));
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("misalign.sticky", 32'(MisalignErr), 32'(MIS_EN));

    // PC wrap at the last word
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 32'hFFC);
    chk("wrap.pc0", Pc, 32'hFFC);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("wrap.pc",    Pc, 32'h0);
    chk("wrap.pc4",   IfIdPcPlus4, 32'h0);
    chk("wrap.inst",  IfIdInst, w(1023));
    chk("wrap.valid", 32'(IfIdValid), 1);

    // halt on word 2
    mem[2] = HW;
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("halt.pc8", Pc, 32'h8);
    chk("halt.h0",  32'(Halted), 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("halt.h1",    32'(Halted), 1);
    chk("halt.pc",    Pc, 32'h8);
    chk("halt.inst",  IfIdInst, HW);
    chk("halt.valid", 32'(IfIdValid), 1);
    chk("halt.cnt",   FetchCount, 3);
    cyc(0, 0, 0, 1, 32'h40, 1, 32'h80);
    chk("halt.jpc",   Pc, 32'h8);
    chk("halt.nop",   IfIdInst, 32'h0);
    chk("halt.nv",    32'(IfIdValid), 0);
    chk("halt.hcnt",  FetchCount, 3);
    chk("halt.hold",  32'(Halted), 1);
    cyc(1, 0, 0, 0, 0, 1, 32'h80);
    chk("halt.rpc",   Pc, 32'h0);
    chk("halt.rh",    32'(Halted), 0);
    chk("halt.rcnt",  FetchCount, 0);
    mem[2] = w(2);

    // randomized run against the model
    for (int i = 0; i < 1024; i++)
      mem[i] = ($urandom % 40 == 0) ? HW : $urandom;
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk_model("r0");
    for (int n = 0; n < 3000; n++) begin
      cyc($urandom % 64 == 0, $urandom % 5 == 0, $urandom % 8 == 0,
          $urandom % 10 == 0, $urandom_range(0, 4095),
          $urandom % 12 == 0, $urandom_range(0, 4095));
      chk_model("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
